// File: rtl/wb_sig_mbox_pkg.sv
// Shared definitions for the signature mailbox: register map, bit positions,
// FSM encoding and a byte-lane merge helper.
package wb_sig_mbox_pkg;

    localparam int unsigned ADR_W      = 3;
    localparam int unsigned DAT_W      = 32;
    localparam int unsigned SEL_W      = 4;
    localparam int unsigned SIG_W      = 16;
    localparam int unsigned HIST_DEPTH = 4;
    localparam int unsigned HIST_PTR_W = 2;
    localparam int unsigned HIST_CNT_W = 3;

    localparam logic [ADR_W-1:0] ADR_SIG    = 3'd0;
    localparam logic [ADR_W-1:0] ADR_CTRL   = 3'd1;
    localparam logic [ADR_W-1:0] ADR_SIGREF = 3'd2;
    localparam logic [ADR_W-1:0] ADR_TMO    = 3'd3;
    localparam logic [ADR_W-1:0] ADR_STATUS = 3'd4;
    localparam logic [ADR_W-1:0] ADR_HIST   = 3'd5;

    localparam int unsigned CTRL_WDT_EN = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_CLR    = 2;

    localparam int unsigned STAT_DONE    = 0;
    localparam int unsigned STAT_PASS    = 1;
    localparam int unsigned STAT_FAIL    = 2;
    localparam int unsigned STAT_EMPTY   = 3;
    localparam int unsigned STAT_FULL    = 4;
    localparam int unsigned STAT_OVF     = 5;
    localparam int unsigned STAT_CNT_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } mbox_state_e;

    // Replace the byte lanes of old_val selected by sel with those of wdat.
    function automatic logic [DAT_W-1:0] byte_merge(input logic [DAT_W-1:0] old_val,
                                                    input logic [DAT_W-1:0] wdat,
                                                    input logic [SEL_W-1:0] sel);
        logic [DAT_W-1:0] res;
        res = old_val;
        for (int b = 0; b < int'(SEL_W); b++) begin
            if (sel[b]) res[b*8 +: 8] = wdat[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sig_hist_fifo.sv
// Four-entry history FIFO of written signatures; flush empties it at once.
module sig_hist_fifo
    import wb_sig_mbox_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [SIG_W-1:0]      din,
    output logic [SIG_W-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [HIST_CNT_W-1:0] count
);

    logic [SIG_W-1:0]      mem [HIST_DEPTH];
    logic [HIST_PTR_W-1:0] wr_ptr;
    logic [HIST_PTR_W-1:0] rd_ptr;
    logic [HIST_CNT_W-1:0] cnt_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == HIST_CNT_W'(HIST_DEPTH));
    assign count = cnt_q;
    assign dout  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(HIST_DEPTH); i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + HIST_PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + HIST_PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + HIST_CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - HIST_CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wb_sig_mbox.sv
// Wishbone-mapped test signature mailbox: tracks start/pass signatures written by
// firmware, a watchdog that flags FAIL, and a history FIFO of written values.
module wb_sig_mbox
    import wb_sig_mbox_pkg::*;
#(
    parameter int unsigned      TMO_W     = 24,
    parameter logic [TMO_W-1:0] TMO_DEF   = 24'd30000,
    parameter logic [SIG_W-1:0] START_DEF = 16'hAB60,
    parameter logic [SIG_W-1:0] PASS_DEF  = 16'hAB6A
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [ADR_W-1:0] wbs_adr_i,
    input  logic [DAT_W-1:0] wbs_dat_i,
    input  logic [SEL_W-1:0] wbs_sel_i,
    output logic             wbs_ack_o,
    output logic             wbs_err_o,
    output logic [DAT_W-1:0] wbs_dat_o,
    output logic [SIG_W-1:0] checkbits_o,
    output logic             test_done_o,
    output logic             test_pass_o,
    output logic             test_fail_o,
    output logic             irq_o
);

    mbox_state_e state_q, state_d;

    logic             ack_q, err_q;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic [SIG_W-1:0] sig_q, sig_d, start_q, start_d, pass_q, pass_d;
    logic [TMO_W-1:0] tmo_q, tmo_d, wdt_q, wdt_d;
    logic             wdt_en_q, wdt_en_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
    logic             done_q, pass_st_q, fail_st_q, irq_q;
    logic             done_d, irq_d;

    logic             req, mapped, wr, rd, sig_wr, hist_pop, clr;
    logic [DAT_W-1:0] regval, wmerge;

    logic [SIG_W-1:0]      fifo_dout;
    logic                  fifo_full, fifo_empty;
    logic [HIST_CNT_W-1:0] fifo_count;

    assign req      = wbs_cyc_i & wbs_stb_i & ~ack_q & ~err_q;
    assign mapped   = (wbs_adr_i <= ADR_HIST);
    assign wr       = req & mapped & wbs_we_i;
    assign rd       = req & mapped & ~wbs_we_i;
    assign sig_wr   = wr & (wbs_adr_i == ADR_SIG);
    assign hist_pop = rd & (wbs_adr_i == ADR_HIST);
    assign clr      = wr & (wbs_adr_i == ADR_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_CLR];
    assign wmerge   = byte_merge(regval, wbs_dat_i, wbs_sel_i);

    // Current value of the addressed register; doubles as read data and write-merge base.
    always_comb begin
        regval = '0;
        case (wbs_adr_i)
            ADR_SIG:    regval[SIG_W-1:0] = sig_q;
            ADR_CTRL: begin
                regval[CTRL_WDT_EN] = wdt_en_q;
                regval[CTRL_IRQ_EN] = irq_en_q;
            end
            ADR_SIGREF: regval = {start_q, pass_q};
            ADR_TMO:    regval[TMO_W-1:0] = tmo_q;
            ADR_STATUS: begin
                regval[STAT_DONE]  = done_q;
                regval[STAT_PASS]  = pass_st_q;
                regval[STAT_FAIL]  = fail_st_q;
                regval[STAT_EMPTY] = fifo_empty;
                regval[STAT_FULL]  = fifo_full;
                regval[STAT_OVF]   = ovf_q;
                regval[STAT_CNT_LSB +: HIST_CNT_W] = fifo_count;
            end
            ADR_HIST:   if (!fifo_empty) regval[SIG_W-1:0] = fifo_dout;
            default:    ;
        endcase
    end

    always_comb begin
        sig_d    = sig_q;
        start_d  = start_q;
        pass_d   = pass_q;
        tmo_d    = tmo_q;
        wdt_en_d = wdt_en_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        wdt_d    = wdt_q;
        dat_d    = rd ? regval : '0;
        if (wr) begin
            case (wbs_adr_i)
                ADR_SIG:    sig_d = wmerge[SIG_W-1:0];
                ADR_CTRL: begin
                    wdt_en_d = wmerge[CTRL_WDT_EN];
                    irq_en_d = wmerge[CTRL_IRQ_EN];
                end
                ADR_SIGREF: begin
                    pass_d  = wmerge[SIG_W-1:0];
                    start_d = wmerge[DAT_W-1:SIG_W];
                end
                ADR_TMO:    tmo_d = wmerge[TMO_W-1:0];
                ADR_STATUS: if (wbs_sel_i[0] && wbs_dat_i[STAT_OVF]) ovf_d = 1'b0;
                default:    ;
            endcase
        end
        if (clr) ovf_d = 1'b0;
        else if (sig_wr && fifo_full && !hist_pop) ovf_d = 1'b1;
        // A SIG write reloads even when the count is already at 0, which pre-empts FAIL.
        if (sig_wr) wdt_d = tmo_q;
        else if (state_q == ST_RUN && wdt_q != '0) wdt_d = wdt_q - TMO_W'(1);
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (sig_wr && sig_d == start_q) state_d = ST_RUN;
                ST_RUN: begin
                    if (sig_wr) begin
                        if (sig_d == pass_q) state_d = ST_PASS;
                    end else if (wdt_en_q && wdt_q == '0) begin
                        state_d = ST_FAIL;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_d = (state_d == ST_PASS) | (state_d == ST_FAIL);
    assign irq_d  = irq_en_d & (done_d | ovf_d);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            sig_q     <= '0;
            start_q   <= START_DEF;
            pass_q    <= PASS_DEF;
            tmo_q     <= TMO_DEF;
            wdt_q     <= '0;
            wdt_en_q  <= 1'b1;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            pass_st_q <= 1'b0;
            fail_st_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ack_q     <= req & mapped;
            err_q     <= req & ~mapped;
            dat_q     <= dat_d;
            sig_q     <= sig_d;
            start_q   <= start_d;
            pass_q    <= pass_d;
            tmo_q     <= tmo_d;
            wdt_q     <= wdt_d;
            wdt_en_q  <= wdt_en_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            pass_st_q <= (state_d == ST_PASS);
            fail_st_q <= (state_d == ST_FAIL);
            irq_q     <= irq_d;
        end
    end

    sig_hist_fifo u_hist (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n),
        .flush (clr),
        .push  (sig_wr),
        .pop   (hist_pop),
        .din   (sig_d),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wbs_ack_o   = ack_q;
    assign wbs_err_o   = err_q;
    assign wbs_dat_o   = dat_q;
    assign checkbits_o = sig_q;
    assign test_done_o = done_q;
    assign test_pass_o = pass_st_q;
    assign test_fail_o = fail_st_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_wb_sig_mbox.sv
// Bench for wb_sig_mbox: directed scenarios plus random bus traffic, every cycle
// compared against a transaction-level model of the mailbox.
module tb_wb_sig_mbox;

    localparam logic [15:0] START = 16'hAB60;
    localparam logic [15:0] PASS  = 16'hAB6A;
    localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;

    logic        wb_clk_i, wb_rst_n;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [2:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_ack_o, wbs_err_o;
    logic [31:0] wbs_dat_o;
    logic [15:0] checkbits_o;
    logic        test_done_o, test_pass_o, test_fail_o, irq_o;

    wb_sig_mbox dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_n    (wb_rst_n),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_err_o   (wbs_err_o),
        .wbs_dat_o   (wbs_dat_o),
        .checkbits_o (checkbits_o),
        .test_done_o (test_done_o),
        .test_pass_o (test_pass_o),
        .test_fail_o (test_fail_o),
        .irq_o       (irq_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %08h expected %08h", tag, cyc_no, obs, exp);
        end
    endtask

    // Reference model: registers, a queue for history, a watchdog count and a state label.
    logic [15:0] m_sig, m_start, m_pass;
    logic [23:0] m_tmo;
    bit          m_wdt_en, m_irq_en, m_ovf, m_ack, m_err;
    logic [31:0] m_dat;
    int          m_state, m_wdt;
    logic [15:0] m_hist[$];

    function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_sig = 16'h0; m_start = START; m_pass = PASS; m_tmo = 24'd30000;
        m_wdt_en = 1'b1; m_irq_en = 1'b0; m_ovf = 1'b0; m_ack = 1'b0; m_err = 1'b0;
        m_dat = 32'h0; m_state = M_IDLE; m_wdt = 0;
        m_hist.delete();
    endtask

    task automatic model_edge(input bit r, input bit w, input logic [2:0] a,
                              input logic [31:0] d, input logic [3:0] s);
        bit sampled, sig_wr, clr, en0;
        int st0, wdt0;
        logic [31:0] v;
        bit done0;
        sampled = r && !m_ack && !m_err;
        st0 = m_state; wdt0 = m_wdt; en0 = m_wdt_en;
        done0 = (st0 == M_PASS) || (st0 == M_FAIL);
        m_ack = 1'b0; m_err = 1'b0; m_dat = 32'h0; sig_wr = 1'b0; clr = 1'b0;
        if (sampled && a >= 3'd6) begin
            m_err = 1'b1;
        end else if (sampled) begin
            m_ack = 1'b1;
            if (w) begin
                case (a)
                    3'd0: begin
                        v = merge32({16'h0, m_sig}, d, s);
                        m_sig = v[15:0];
                        sig_wr = 1'b1;
                        if (m_hist.size() < 4) m_hist.push_back(m_sig);
                        else m_ovf = 1'b1;
                    end
                    3'd1: if (s[0]) begin m_wdt_en = d[0]; m_irq_en = d[1]; clr = d[2]; end
                    3'd2: begin v = merge32({m_start, m_pass}, d, s); {m_start, m_pass} = v; end
                    3'd3: begin v = merge32({8'h0, m_tmo}, d, s); m_tmo = v[23:0]; end
                    3'd4: if (s[0] && d[5]) m_ovf = 1'b0;
                    default: ;
                endcase
            end else begin
                case (a)
                    3'd0: m_dat = {16'h0, m_sig};
                    3'd1: m_dat = {30'h0, m_irq_en, m_wdt_en};
                    3'd2: m_dat = {m_start, m_pass};
                    3'd3: m_dat = {8'h0, m_tmo};
                    3'd4: m_dat = 32'(done0) | (32'(st0 == M_PASS) << 1) | (32'(st0 == M_FAIL) << 2)
                                | (32'(m_hist.size() == 0) << 3) | (32'(m_hist.size() == 4) << 4)
                                | (32'(m_ovf) << 5) | (32'(m_hist.size()) << 8);
                    3'd5: if (m_hist.size() > 0) m_dat = {16'h0, m_hist.pop_front()};
                    default: ;
                endcase
            end
        end
        if (clr) begin m_state = M_IDLE; m_hist.delete(); m_ovf = 1'b0; end
        if (sig_wr) begin
            m_wdt = int'(m_tmo);
            if (st0 == M_IDLE && m_sig == m_start) m_state = M_RUN;
            else if (st0 == M_RUN && m_sig == m_pass) m_state = M_PASS;
        end else if (st0 == M_RUN) begin
            if (!clr && wdt0 == 0 && en0) m_state = M_FAIL;
            if (wdt0 > 0) m_wdt = wdt0 - 1;
        end
    endtask

    task automatic compare_all();
        bit done;
        done = (m_state == M_PASS) || (m_state == M_FAIL);
        chk("ack", 32'(wbs_ack_o), 32'(m_ack));
        chk("err", 32'(wbs_err_o), 32'(m_err));
        chk("dat", wbs_dat_o, m_dat);
        chk("checkbits", 32'(checkbits_o), 32'(m_sig));
        chk("done", 32'(test_done_o), 32'(done));
        chk("pass", 32'(test_pass_o), 32'(m_state == M_PASS));
        chk("fail", 32'(test_fail_o), 32'(m_state == M_FAIL));
        chk("irq", 32'(irq_o), 32'(m_irq_en & (done | m_ovf)));
    endtask

    task automatic cyc_step(input bit r, input bit w, input logic [2:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        wbs_cyc_i = r; wbs_stb_i = r; wbs_we_i = w;
        wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
        @(posedge wb_clk_i);
        cyc_no++;
        model_edge(r, w, a, d, s);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_step(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc_step(1'b1, 1'b1, a, d, s);
        idle(1);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        cyc_step(1'b1, 1'b0, a, 32'h0, 4'hF);
        v = wbs_dat_o;
        idle(1);
    endtask

    // Reset from posedge+1; optionally with a request in flight that must be dropped.
    task automatic apply_reset(input bit mid_req);
        if (mid_req) begin
            wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
            wbs_adr_i = 3'd0; wbs_dat_i = 32'h0000_FFFF; wbs_sel_i = 4'hF;
        end
        #2 wb_rst_n = 1'b0;
        #1;
        chk("rst_ack", 32'(wbs_ack_o), 32'h0);
        chk("rst_err", 32'(wbs_err_o), 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_checkbits", 32'(checkbits_o), 32'h0);
        chk("rst_flags", 32'({test_done_o, test_pass_o, test_fail_o, irq_o}), 32'h0);
        model_reset();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge wb_clk_i);
        #1 wb_rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] v, d;
        logic [2:0]  a;
        logic [3:0]  s;
        bit          r, w;
        int          n, pick;

        wb_rst_n = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_adr_i = 3'd0; wbs_dat_i = 32'h0; wbs_sel_i = 4'h0;
        model_reset();
        @(posedge wb_clk_i);
        #1 apply_reset(1'b0);
        idle(1);

        // Reset values of the registers
        rd(3'd1, v); chk("ctrl_reset", v, 32'h0000_0001);
        rd(3'd2, v); chk("sigref_reset", v, 32'hAB60_AB6A);
        rd(3'd3, v); chk("tmo_reset", v, 32'd30000);
        rd(3'd4, v); chk("status_reset", v, 32'h0000_0008);

        // Start then pass signature
        wr(3'd0, {16'h0, START}, 4'hF); chk("cb_start", 32'(checkbits_o), 32'h0000_AB60);
        wr(3'd0, {16'h0, PASS}, 4'hF);  chk("cb_pass", 32'(checkbits_o), 32'h0000_AB6A);
        chk("pass_flag", 32'(test_pass_o), 32'h1);
        rd(3'd4, v); chk("status_pass", v, 32'h0000_0203);

        // Byte-lane SIG write
        apply_reset(1'b0);
        wr(3'd0, {16'h0, START}, 4'hF);
        wr(3'd0, 32'h0000_00FF, 4'b0001); chk("cb_bytelane", 32'(checkbits_o), 32'h0000_ABFF);

        // History overflow and drain
        apply_reset(1'b0);
        for (int i = 1; i <= 5; i++) wr(3'd0, 32'(i), 4'hF);
        rd(3'd4, v); chk("status_ovf_full", v, 32'h0000_0430);
        for (int i = 1; i <= 4; i++) begin rd(3'd5, v); chk("hist_pop", v, 32'(i)); end
        rd(3'd5, v); chk("hist_empty_rd", v, 32'h0);
        rd(3'd4, v); chk("status_drained", v, 32'h0000_0028);
        wr(3'd4, 32'h0000_0020, 4'hF);
        rd(3'd4, v); chk("status_w1c", v, 32'h0000_0008);

        // Unmapped addresses
        cyc_step(1'b1, 1'b1, 3'd6, 32'hFFFF_FFFF, 4'hF);
        chk("unmapped_err", 32'(wbs_err_o), 32'h1);
        chk("unmapped_noack", 32'(wbs_ack_o), 32'h0);
        idle(1);
        chk("unmapped_err_pulse", 32'(wbs_err_o), 32'h0);
        cyc_step(1'b1, 1'b0, 3'd7, 32'h0, 4'hF);
        chk("unmapped_rd_dat", wbs_dat_o, 32'h0);
        idle(1);

        // Watchdog timeout latency, then irq and clear
        apply_reset(1'b0);
        wr(3'd3, 32'd100, 4'hF);
        cyc_step(1'b1, 1'b1, 3'd0, {16'h0, START}, 4'hF);
        n = 0;
        while (!test_fail_o && n < 300) begin idle(1); n++; end
        chk("wdt_latency_in_range", 32'(n >= 100 && n <= 101), 32'h1);
        wr(3'd1, 32'h0000_0003, 4'hF); chk("irq_on_done", 32'(irq_o), 32'h1);
        wr(3'd1, 32'h0000_0007, 4'hF); chk("clr_done", 32'(test_done_o), 32'h0);
        chk("clr_irq", 32'(irq_o), 32'h0);
        chk("clr_keeps_cb", 32'(checkbits_o), 32'h0000_AB60);

        // SIG write in the cycle the watchdog reaches zero wins
        apply_reset(1'b0);
        wr(3'd3, 32'd3, 4'hF);
        cyc_step(1'b1, 1'b1, 3'd0, {16'h0, START}, 4'hF);
        idle(3);
        cyc_step(1'b1, 1'b1, 3'd0, 32'h0000_1234, 4'hF);
        idle(1);
        chk("sig_beats_wdt", 32'(test_fail_o), 32'h0);

        // Reset during RUN with a request in flight
        apply_reset(1'b0);
        wr(3'd0, {16'h0, START}, 4'hF);
        idle(2);
        apply_reset(1'b1);
        idle(1);
        wr(3'd0, {16'h0, PASS}, 4'hF);
        chk("post_rst_idle", 32'(test_pass_o), 32'h0);

        // Random traffic
        apply_reset(1'b0);
        wr(3'd3, 32'd12, 4'hF);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 1) == 1);
            w = ($urandom_range(0, 1) == 1);
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            d = $urandom;
            pick = int'($urandom_range(0, 9));
            case (pick)
                0, 1, 2, 3: begin
                    a = 3'd0;
                    case ($urandom_range(0, 3))
                        0: d = {d[31:16], m_start};
                        1: d = {d[31:16], m_pass};
                        default: ;
                    endcase
                end
                4: begin
                    a = 3'd1;
                    d = {29'h0, 1'($urandom_range(0, 3) == 0), 1'($urandom),
                         1'($urandom_range(0, 5) != 0)};
                end
                5: begin a = 3'd3; d = 32'($urandom_range(0, 40)); s = 4'hF; end
                6: a = 3'd4;
                7: a = 3'd5;
                8: begin a = 3'd2; if ($urandom_range(0, 7) != 0) w = 1'b0; end
                default: a = 3'($urandom_range(6, 7));
            endcase
            cyc_step(r, w, a, d, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
